// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: NOP encoding, base opcodes, fetch FSM states and
// the IF/ID pipeline register layout used by fetch and the main decoder.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads d_i when enabled, loads BUBBLE on reset or
// flush. Flush wins over enable so a flush during a stall still bubbles.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter if_id_t BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0}
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en_i,
  input  logic   flush_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t q_q;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      q_q <= BUBBLE;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, next-PC selection, BOOT/RUN/HALT
// control, misaligned-redirect fault capture and the IF/ID register.
module fetch_stage
  import riscv_pkg::fetch_state_t, riscv_pkg::if_id_t,
         riscv_pkg::BOOT, riscv_pkg::RUN, riscv_pkg::HALT;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_f,
  input  logic            flush_d,
  input  logic            pc_src_e,
  input  logic [XLEN-1:0] pc_target_e,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d,
  output logic            halted,
  output logic [XLEN-1:0] fault_pc,
  output fetch_state_t    state_o
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;
  logic            halted_q, halted_d;
  logic [XLEN-1:0] seq_pc;
  logic            misaligned;
  logic            ifid_en;
  logic            ifid_flush;
  if_id_t          ifid_in;
  if_id_t          ifid_q;

  assign seq_pc     = fetch_pc_q + XLEN'(4);
  assign misaligned = (pc_target_e[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (pc_src_e && misaligned) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // Redirect beats stall for the PC; flush beats stall for IF/ID.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    fault_pc_d = fault_pc_q;
    halted_d   = halted_q;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    case (state_q)
      BOOT: begin
        ifid_flush = 1'b1;
      end
      RUN: begin
        if (pc_src_e && misaligned) begin
          fault_pc_d = pc_target_e;
          halted_d   = 1'b1;
          ifid_flush = 1'b1;
        end else if (pc_src_e) begin
          fetch_pc_d = pc_target_e;
          ifid_flush = 1'b1;
        end else if (stall_f) begin
          ifid_flush = flush_d;
        end else begin
          fetch_pc_d = seq_pc;
          ifid_en    = 1'b1;
          ifid_flush = flush_d;
        end
      end
      default: begin
        ifid_flush = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      fault_pc_q <= '0;
      halted_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      fault_pc_q <= fault_pc_d;
      halted_q   <= halted_d;
    end
  end

  assign ifid_in = '{instr: imem_rdata, pc: fetch_pc_q, pc_plus4: seq_pc, valid: 1'b1};

  if_id_reg #(
    .BUBBLE('{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0})
  ) u_if_id_reg (
    .clk    (clk),
    .rst    (rst),
    .en_i   (ifid_en),
    .flush_i(ifid_flush),
    .d_i    (ifid_in),
    .q_o    (ifid_q)
  );

  assign imem_addr  = fetch_pc_q;
  assign instr_d    = ifid_q.instr;
  assign pc_d       = ifid_q.pc;
  assign pc_plus4_d = ifid_q.pc_plus4;
  assign valid_d    = ifid_q.valid;
  assign halted     = halted_q;
  assign fault_pc   = fault_pc_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios from reset, redirect, stall,
// flush, fault and PC wrap, then random traffic against a behavioural model.
module tb_fetch_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall_f, flush_d, pc_src_e;
  logic [31:0] pc_target_e, imem_addr, imem_rdata;
  logic [31:0] instr_d, pc_d, pc_plus4_d, fault_pc;
  logic        valid_d, halted;
  fetch_state_t state_o;

  logic        rst_w;
  logic        zero_w = 1'b0;
  logic [31:0] tgt_w = 32'h0;
  logic [31:0] imem_addr_w, imem_rdata_w, instr_d_w, pc_d_w, pc_plus4_d_w, fault_pc_w;
  logic        valid_d_w, halted_w;
  fetch_state_t state_w;

  int n_checks = 0;
  int n_fail   = 0;

  // Instruction memory: word at byte address 4*i holds 4*i+1.
  assign imem_rdata   = imem_addr + 32'd1;
  assign imem_rdata_w = imem_addr_w + 32'd1;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall_f(stall_f), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .valid_d(valid_d), .halted(halted), .fault_pc(fault_pc), .state_o(state_o)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst_w), .stall_f(zero_w), .flush_d(zero_w),
    .pc_src_e(zero_w), .pc_target_e(tgt_w),
    .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
    .instr_d(instr_d_w), .pc_d(pc_d_w), .pc_plus4_d(pc_plus4_d_w),
    .valid_d(valid_d_w), .halted(halted_w), .fault_pc(fault_pc_w), .state_o(state_w)
  );

  // Behavioural model state.
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4, m_fault;
  logic        m_valid, m_halt, m_boot;
  logic [31:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall_f = 1'b0; flush_d = 1'b0; pc_src_e = 1'b0; pc_target_e = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic run_to_pc(input logic [31:0] a);
    int budget = 64;
    while (imem_addr !== a && budget > 0) begin
      tick();
      budget--;
    end
    n_checks++;
    if (imem_addr !== a) begin
      n_fail++;
      $display("FAIL run_to_pc: imem_addr=%h never reached %h", imem_addr, a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stall_f = 1'b1; flush_d = 1'b0; pc_src_e = 1'b1; pc_target_e = 32'h0000_0080;
    tick();
    n_checks++;
    if ({imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, halted, fault_pc} !==
        {32'h0, NOP_INSTR, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0} || state_o !== BOOT) begin
      n_fail++;
      $display("FAIL reset_values: addr=%h instr=%h pc_d=%h pc4=%h v=%b h=%b f=%h st=%0d",
               imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, halted, fault_pc, state_o);
    end
    // BOOT cycle: the redirect and stall driven here must be ignored.
    rst = 1'b0;
    tick();
    clear_inputs();
    n_checks++;
    if (imem_addr !== 32'h0 || instr_d !== NOP_INSTR || valid_d !== 1'b0 || state_o !== RUN) begin
      n_fail++;
      $display("FAIL boot_bubble: addr=%h instr=%h v=%b st=%0d expected 0 %h 0 RUN",
               imem_addr, instr_d, valid_d, state_o, NOP_INSTR);
    end
    tick();
    n_checks++;
    if (instr_d !== 32'h1 || pc_d !== 32'h0 || pc_plus4_d !== 32'h4 || valid_d !== 1'b1) begin
      n_fail++;
      $display("FAIL first_fetch: instr=%h pc_d=%h pc4=%h v=%b expected 1 0 4 1",
               instr_d, pc_d, pc_plus4_d, valid_d);
    end
    tick();
    n_checks++;
    if (instr_d !== 32'h5 || pc_d !== 32'h4 || pc_plus4_d !== 32'h8 || valid_d !== 1'b1) begin
      n_fail++;
      $display("FAIL second_fetch: instr=%h pc_d=%h pc4=%h v=%b expected 5 4 8 1",
               instr_d, pc_d, pc_plus4_d, valid_d);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    run_to_pc(32'h10);
    pc_src_e = 1'b1; pc_target_e = 32'h40;
    tick();
    clear_inputs();
    n_checks++;
    if (imem_addr !== 32'h40 || instr_d !== NOP_INSTR || valid_d !== 1'b0 || pc_d !== 32'h0) begin
      n_fail++;
      $display("FAIL redirect_bubble: addr=%h instr=%h v=%b pc_d=%h expected 40 nop 0 0",
               imem_addr, instr_d, valid_d, pc_d);
    end
    tick();
    n_checks++;
    if (pc_d !== 32'h40 || pc_plus4_d !== 32'h44 || instr_d !== 32'h41 || valid_d !== 1'b1) begin
      n_fail++;
      $display("FAIL redirect_target: pc_d=%h pc4=%h instr=%h v=%b expected 40 44 41 1",
               pc_d, pc_plus4_d, instr_d, valid_d);
    end
  endtask

  task automatic test_stall();
    do_reset();
    run_to_pc(32'h8);
    stall_f = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (imem_addr !== 32'h8 || instr_d !== 32'h5 || pc_d !== 32'h4 || valid_d !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: addr=%h instr=%h pc_d=%h v=%b expected 8 5 4 1",
                 k, imem_addr, instr_d, pc_d, valid_d);
      end
    end
    stall_f = 1'b0;
    tick();
    n_checks++;
    if (instr_d !== 32'h9 || pc_d !== 32'h8 || imem_addr !== 32'hC || valid_d !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: instr=%h pc_d=%h addr=%h v=%b expected 9 8 c 1",
               instr_d, pc_d, imem_addr, valid_d);
    end
  endtask

  task automatic test_stall_redirect_flush();
    do_reset();
    run_to_pc(32'hC);
    stall_f = 1'b1; pc_src_e = 1'b1; pc_target_e = 32'h100;
    tick();
    n_checks++;
    if (imem_addr !== 32'h100 || instr_d !== NOP_INSTR || valid_d !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_plus_redirect: addr=%h instr=%h v=%b expected 100 nop 0",
               imem_addr, instr_d, valid_d);
    end
    pc_src_e = 1'b0; flush_d = 1'b1;
    tick();
    n_checks++;
    if (imem_addr !== 32'h100 || instr_d !== NOP_INSTR || valid_d !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_plus_flush: addr=%h instr=%h v=%b expected 100 nop 0",
               imem_addr, instr_d, valid_d);
    end
    clear_inputs();
    tick();
    n_checks++;
    if (instr_d !== 32'h101 || pc_d !== 32'h100 || valid_d !== 1'b1 || imem_addr !== 32'h104) begin
      n_fail++;
      $display("FAIL after_flush: instr=%h pc_d=%h v=%b addr=%h expected 101 100 1 104",
               instr_d, pc_d, valid_d, imem_addr);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    run_to_pc(32'h10);
    pc_src_e = 1'b1; pc_target_e = 32'h42;
    tick();
    clear_inputs();
    n_checks++;
    if (halted !== 1'b1 || fault_pc !== 32'h42 || imem_addr !== 32'h10 ||
        valid_d !== 1'b0 || state_o !== HALT) begin
      n_fail++;
      $display("FAIL fault_entry: h=%b f=%h addr=%h v=%b st=%0d expected 1 42 10 0 HALT",
               halted, fault_pc, imem_addr, valid_d, state_o);
    end
    for (int k = 0; k < 5; k++) begin
      stall_f = 1'($urandom_range(0, 1)); flush_d = 1'($urandom_range(0, 1));
      pc_src_e = 1'($urandom_range(0, 1)); pc_target_e = {$urandom_range(0, 255), 2'b00};
      tick();
      n_checks++;
      if (halted !== 1'b1 || fault_pc !== 32'h42 || imem_addr !== 32'h10 || valid_d !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_sticky[%0d]: h=%b f=%h addr=%h v=%b expected 1 42 10 0",
                 k, halted, fault_pc, imem_addr, valid_d);
      end
    end
    do_reset();
    n_checks++;
    if ({imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, halted, fault_pc} !==
        {32'h0, NOP_INSTR, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0} || state_o !== BOOT) begin
      n_fail++;
      $display("FAIL halt_reset: addr=%h instr=%h h=%b f=%h st=%0d expected reset values",
               imem_addr, instr_d, halted, fault_pc, state_o);
    end
  endtask

  task automatic test_wrap();
    rst_w = 1'b1;
    tick();
    rst_w = 1'b0;
    tick();
    tick();
    n_checks++;
    if (pc_d_w !== 32'hFFFF_FFFC || pc_plus4_d_w !== 32'h0 || instr_d_w !== 32'hFFFF_FFFD) begin
      n_fail++;
      $display("FAIL wrap_first: pc_d=%h pc4=%h instr=%h expected fffffffc 0 fffffffd",
               pc_d_w, pc_plus4_d_w, instr_d_w);
    end
    tick();
    n_checks++;
    if (pc_d_w !== 32'h0 || pc_plus4_d_w !== 32'h4 || instr_d_w !== 32'h1 || valid_d_w !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_second: pc_d=%h pc4=%h instr=%h v=%b expected 0 4 1 1",
               pc_d_w, pc_plus4_d_w, instr_d_w, valid_d_w);
    end
  endtask

  // Model advance for one clock edge under the inputs currently driven.
  task automatic model_step();
    logic bubble;
    bubble = 1'b0;
    if (rst) begin
      m_pc = 32'h0; m_halt = 1'b0; m_fault = 32'h0; m_boot = 1'b1; bubble = 1'b1;
    end else if (m_boot) begin
      m_boot = 1'b0; bubble = 1'b1;
    end else if (m_halt) begin
      bubble = 1'b1;
    end else if (pc_src_e && (pc_target_e % 4 != 0)) begin
      m_halt = 1'b1; m_fault = pc_target_e; bubble = 1'b1;
    end else if (pc_src_e) begin
      m_pc = pc_target_e; bubble = 1'b1;
    end else if (stall_f) begin
      bubble = flush_d;
    end else if (flush_d) begin
      m_pc = m_pc + 32'd4; bubble = 1'b1;
    end else begin
      m_instr = m_pc + 32'd1; m_pcd = m_pc; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
    end
    if (bubble) begin
      m_instr = NOP_INSTR; m_pcd = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end
  endtask

  task automatic test_random();
    clear_inputs();
    rst = 1'b1;
    model_step();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 59) == 0);
      stall_f  = ($urandom_range(0, 3) == 0);
      flush_d  = ($urandom_range(0, 5) == 0);
      pc_src_e = ($urandom_range(0, 7) == 0);
      pc_target_e = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 15) == 0) pc_target_e[1:0] = 2'($urandom_range(1, 3));
      model_step();
      tick();
      exp_q = {m_pc, m_instr, m_pcd, m_pc4, 32'(m_valid), 32'(m_halt), m_fault};
      n_checks++;
      if (imem_addr !== exp_q[0] || instr_d !== exp_q[1] || pc_d !== exp_q[2] ||
          pc_plus4_d !== exp_q[3] || 32'(valid_d) !== exp_q[4] ||
          32'(halted) !== exp_q[5] || fault_pc !== exp_q[6]) begin
        n_fail++;
        $display("FAIL random[%0d]: got addr=%h instr=%h pc_d=%h pc4=%h v=%b h=%b f=%h exp %h %h %h %h %0d %0d %h",
                 i, imem_addr, instr_d, pc_d, pc_plus4_d, valid_d, halted, fault_pc,
                 exp_q[0], exp_q[1], exp_q[2], exp_q[3], exp_q[4], exp_q[5], exp_q[6]);
      end
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1; rst_w = 1'b1;
    clear_inputs();
    tick();
    test_reset();
    test_redirect();
    test_stall();
    test_stall_redirect_flush();
    test_misaligned();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
